// File: rtl/aap_fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory port, decoder-side output and branch redirect.
// master = sequencer side, slave = memory/decoder/branch environment side.
interface aap_fetch_sequencer_if #(
   parameter int unsigned ADDR_W = 24
) ();
   localparam int unsigned PARCEL_W = 16;
   localparam int unsigned INSTR_W  = 32;

   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic                imem_ack;
   logic [PARCEL_W-1:0] imem_rdata;
   logic                stall;
   logic                branch_valid;
   logic [ADDR_W-1:0]   branch_target;
   logic [INSTR_W-1:0]  fetchoutput;
   logic                fetch_valid;
   logic [ADDR_W-1:0]   fetch_pc;
   logic                fetch_err;

   modport master (
      output imem_req, imem_addr, fetchoutput, fetch_valid, fetch_pc, fetch_err,
      input  imem_ack, imem_rdata, stall, branch_valid, branch_target
   );

   modport slave (
      input  imem_req, imem_addr, fetchoutput, fetch_valid, fetch_pc, fetch_err,
      output imem_ack, imem_rdata, stall, branch_valid, branch_target
   );
endinterface

// File: rtl/aap_fetch_sequencer.sv
// Fetch/issue controller: reads 16-bit parcels, assembles short/long instructions, services redirects.
// Optional malformed-long-instruction check enabled by defining FETCH_LONG_CHECK_EN.
module aap_fetch_sequencer #(
   parameter int unsigned       ADDR_W   = 24,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   aap_fetch_sequencer_if.master bus
);
   localparam int unsigned PARCEL_W = 16;
   localparam int unsigned INSTR_W  = 32;

   typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, HOLD} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   pend_pc;
   logic                discard;
   logic [INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]   instr_pc;
   logic                in_req;

   assign in_req           = (state == REQ_LO) || (state == REQ_HI);
   assign bus.imem_req     = in_req;
   assign bus.imem_addr    = pc;
   assign bus.fetchoutput  = instr;
   assign bus.fetch_valid  = (state == HOLD);
   assign bus.fetch_pc     = instr_pc;

   // Branch has priority everywhere; a branch without ack waits for the in-flight parcel to drain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         pend_pc  <= RESET_PC;
         discard  <= 1'b0;
         instr    <= '0;
         instr_pc <= RESET_PC;
      end else begin
         unique case (state)
            IDLE: begin
               state <= REQ_LO;
               if (bus.branch_valid) pc <= bus.branch_target;
            end
            REQ_LO, REQ_HI: begin
               if (bus.imem_ack && (discard || bus.branch_valid)) begin
                  pc      <= bus.branch_valid ? bus.branch_target : pend_pc;
                  discard <= 1'b0;
                  state   <= REQ_LO;
               end else if (bus.branch_valid) begin
                  pend_pc <= bus.branch_target;
                  discard <= 1'b1;
               end else if (bus.imem_ack) begin
                  pc <= pc + ADDR_W'(1);
                  if (state == REQ_LO) begin
                     instr    <= {bus.imem_rdata, PARCEL_W'(0)};
                     instr_pc <= pc;
                     state    <= bus.imem_rdata[PARCEL_W-1] ? REQ_HI : HOLD;
                  end else begin
                     instr[PARCEL_W-1:0] <= bus.imem_rdata;
                     state               <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.branch_valid) begin
                  pc    <= bus.branch_target;
                  state <= REQ_LO;
               end else if (!bus.stall) begin
                  state <= REQ_LO;
               end
            end
         endcase
      end
   end

`ifdef FETCH_LONG_CHECK_EN
   logic err;
   logic take_parcel;

   assign take_parcel  = in_req && bus.imem_ack && !discard && !bus.branch_valid;
   assign bus.fetch_err = err;

   // Error flag reflects the instruction entering HOLD: set when a long instruction's p1 lacks bit 15.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (bus.branch_valid) begin
         err <= 1'b0;
      end else if (take_parcel) begin
         if (state == REQ_HI) begin
            err <= !bus.imem_rdata[PARCEL_W-1];
         end else if (!bus.imem_rdata[PARCEL_W-1]) begin
            err <= 1'b0;
         end
      end
   end
`else
   assign bus.fetch_err = 1'b0;
`endif

endmodule
